// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: CPU and HOST request/ack buses plus the shared data-memory port.
// slave is the arbiter's view; master is the processor/host/memory side.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              busy;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, host_req, host_we, host_addr, host_wdata, mem_dout,
        output cpu_ack, cpu_rdata, cpu_stall, host_ack, host_rdata, mem_we, mem_addr, mem_din, busy
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, host_req, host_we, host_addr, host_wdata, mem_dout,
        input  cpu_ack, cpu_rdata, cpu_stall, host_ack, host_rdata, mem_we, mem_addr, mem_din, busy
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one data memory between CPU and HOST with a fixed
// 3-cycle IDLE -> ACCESS -> RESP handshake, round-robin or CPU-first on ties.
module data_mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter bit FIXED_PRI = 1'b0
) (
    input logic clk,
    input logic reset,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, next_state;
    logic owner, last_grant, grant_host, lat_we;  // owner/last_grant: 1 = HOST
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata, rdata_reg;
    always_comb begin
        grant_host = bus.host_req & (~bus.cpu_req | (~FIXED_PRI & ~last_grant));
        next_state = (state == IDLE)   ? ((bus.cpu_req | bus.host_req) ? ACCESS : IDLE) :
                     (state == ACCESS) ? RESP : IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_reg  <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && (bus.cpu_req || bus.host_req)) begin
                owner      <= grant_host;
                last_grant <= grant_host;
                lat_we     <= grant_host ? bus.host_we : bus.cpu_we;
                lat_addr   <= grant_host ? bus.host_addr : bus.cpu_addr;
                lat_wdata  <= grant_host ? bus.host_wdata : bus.cpu_wdata;
            end
            if (state == ACCESS && !lat_we) rdata_reg <= bus.mem_dout;
        end
    end
    assign bus.mem_we     = (state == ACCESS) & lat_we;
    assign bus.mem_addr   = lat_addr;
    assign bus.mem_din    = lat_wdata;
    assign bus.cpu_ack    = (state == RESP) & ~owner;
    assign bus.host_ack   = (state == RESP) & owner;
    assign bus.cpu_rdata  = rdata_reg;
    assign bus.host_rdata = rdata_reg;
    assign bus.cpu_stall  = bus.cpu_req & ~bus.cpu_ack;
    assign bus.busy       = state != IDLE;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: scoreboard bench; expected acks (owner, cycle, read data) are
// queued when requests are driven and checked by a monitor when an ack appears.
module tb_data_mem_arbiter;
    typedef struct {
        logic        host;
        logic        chk;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    exp_t sb[$];
    logic [15:0] mem_rr [32];
    logic [15:0] mem_fp [32];
    data_mem_arbiter_if cif ();
    data_mem_arbiter_if fif ();
    data_mem_arbiter #(.FIXED_PRI(1'b0)) dut (.clk(clk), .reset(reset), .bus(cif));
    data_mem_arbiter #(.FIXED_PRI(1'b1)) dut_fp (.clk(clk), .reset(reset), .bus(fif));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (cif.mem_we) mem_rr[cif.mem_addr] <= cif.mem_din;
    always @(posedge clk) if (fif.mem_we) mem_fp[fif.mem_addr] <= fif.mem_din;
    assign cif.mem_dout = mem_rr[cif.mem_addr];
    assign fif.mem_dout = mem_fp[fif.mem_addr];

    always @(negedge clk) begin
        exp_t e;
        if (!reset && (cif.cpu_ack || cif.host_ack)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL ack_unexpected cyc=%0d cpu_ack=%b host_ack=%b want no ack", cyc, cif.cpu_ack, cif.host_ack);
            end else begin
                e = sb.pop_front();
                if ((cif.cpu_ack && cif.host_ack) || cif.host_ack !== e.host || cyc !== e.cyc ||
                    (e.chk && (e.host ? cif.host_rdata : cif.cpu_rdata) !== e.rdata)) begin
                    bad++;
                    $display("FAIL ack_check got cyc=%0d cpu_ack=%b host_ack=%b rdata=%h want cyc=%0d host=%b rdata=%h(chk=%b)",
                             cyc, cif.cpu_ack, cif.host_ack, e.host ? cif.host_rdata : cif.cpu_rdata, e.cyc, e.host, e.rdata, e.chk);
                end
            end
        end
    end

    task automatic at(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic txn(input logic host, input logic we, input logic [4:0] a, input logic [15:0] d,
                       input logic [15:0] exp, output int we_cnt, output int stall_cnt, output logic acked);
        @(posedge clk);
        #1;
        if (host) begin
            cif.host_req = 1'b1; cif.host_we = we; cif.host_addr = a; cif.host_wdata = d;
        end else begin
            cif.cpu_req = 1'b1; cif.cpu_we = we; cif.cpu_addr = a; cif.cpu_wdata = d;
        end
        sb.push_back('{host, !we, exp, cyc + 2});
        we_cnt = 0;
        stall_cnt = 0;
        acked = 1'b0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(negedge clk);
            if (cif.mem_we) we_cnt++;
            if (cif.cpu_stall) stall_cnt++;
            acked = host ? cif.host_ack : cif.cpu_ack;
        end
        @(posedge clk);
        #1;
        cif.cpu_req = 1'b0;
        cif.host_req = 1'b0;
    endtask

    task automatic pending_check(input string name);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_pending got=%0d outstanding acks want=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({cif.busy, cif.mem_we, cif.cpu_ack, cif.host_ack, cif.cpu_stall, fif.busy, fif.mem_we} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl got busy=%b mem_we=%b acks=%b%b stall=%b fp_busy=%b want all 0",
                     cif.busy, cif.mem_we, cif.cpu_ack, cif.host_ack, cif.cpu_stall, fif.busy);
        end
        total++;
        if ({cif.cpu_rdata, cif.host_rdata, cif.mem_addr, cif.mem_din} !== 53'b0) begin
            bad++;
            $display("FAIL reset_regs got rdata=%h/%h addr=%h din=%h want 0", cif.cpu_rdata, cif.host_rdata, cif.mem_addr, cif.mem_din);
        end
        cif.cpu_req = 1'b1;
        #1;
        total++;
        if (cif.cpu_stall !== 1'b1) begin
            bad++;
            $display("FAIL reset_stall got=%b want=1", cif.cpu_stall);
        end
        cif.cpu_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_tie_rr;
        int c;
        @(posedge clk);
        #1;
        cif.cpu_req = 1'b1; cif.cpu_we = 1'b1; cif.cpu_addr = 5'd1; cif.cpu_wdata = 16'h1111;
        cif.host_req = 1'b1; cif.host_we = 1'b1; cif.host_addr = 5'd2; cif.host_wdata = 16'h2222;
        c = cyc;
        sb.push_back('{1'b0, 1'b0, 16'h0, c + 2});
        sb.push_back('{1'b1, 1'b0, 16'h0, c + 5});
        sb.push_back('{1'b0, 1'b0, 16'h0, c + 8});
        sb.push_back('{1'b1, 1'b0, 16'h0, c + 11});
        at(c + 12);
        cif.cpu_req = 1'b0;
        cif.host_req = 1'b0;
        at(c + 14);
        pending_check("tie_rr");
    endtask

    task automatic test_cpu_rw;
        int w, s;
        logic ok;
        txn(1'b0, 1'b1, 5'd5, 16'h1234, 16'h0, w, s, ok);
        total++;
        if (!ok || w != 1 || s != 2) begin
            bad++;
            $display("FAIL cpu_write got ack=%b we_cycles=%0d stall_cycles=%0d want 1/1/2", ok, w, s);
        end
        txn(1'b0, 1'b0, 5'd5, 16'h0, 16'h1234, w, s, ok);
        total++;
        if (!ok || w != 0 || s != 2) begin
            bad++;
            $display("FAIL cpu_read got ack=%b we_cycles=%0d stall_cycles=%0d want 1/0/2", ok, w, s);
        end
        pending_check("cpu_rw");
    endtask

    task automatic test_host_cpu;
        int w, s;
        logic ok;
        txn(1'b1, 1'b1, 5'd31, 16'hBEEF, 16'h0, w, s, ok);
        total++;
        if (!ok || w != 1) begin
            bad++;
            $display("FAIL host_write got ack=%b we_cycles=%0d want 1/1", ok, w);
        end
        txn(1'b0, 1'b0, 5'd31, 16'h0, 16'hBEEF, w, s, ok);
        total++;
        if (!ok || w != 0 || s != 2) begin
            bad++;
            $display("FAIL cpu_read31 got ack=%b we_cycles=%0d stall_cycles=%0d want 1/0/2", ok, w, s);
        end
        pending_check("host_cpu");
    endtask

    task automatic test_back_to_back;
        int c;
        @(posedge clk);
        #1;
        cif.cpu_req = 1'b1; cif.cpu_we = 1'b0; cif.cpu_addr = 5'd31;
        c = cyc;
        sb.push_back('{1'b0, 1'b1, 16'hBEEF, c + 2});
        at(c + 1);
        cif.host_req = 1'b1; cif.host_we = 1'b0; cif.host_addr = 5'd5;
        sb.push_back('{1'b1, 1'b1, 16'h1234, c + 5});
        sb.push_back('{1'b0, 1'b1, 16'hBEEF, c + 8});
        at(c + 6);
        cif.host_req = 1'b0;
        at(c + 9);
        cif.cpu_req = 1'b0;
        at(c + 11);
        pending_check("back_to_back");
    endtask

    task automatic test_drop_req;
        int c;
        @(posedge clk);
        #1;
        cif.cpu_req = 1'b1; cif.cpu_we = 1'b0; cif.cpu_addr = 5'd5;
        c = cyc;
        sb.push_back('{1'b0, 1'b1, 16'h1234, c + 2});
        at(c + 1);
        cif.cpu_req = 1'b0; cif.cpu_addr = 5'd7; cif.cpu_we = 1'b1;
        @(negedge clk);
        total++;
        if (cif.mem_addr !== 5'd5 || cif.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL drop_latched got addr=%0d we=%b want addr=5 we=0", cif.mem_addr, cif.mem_we);
        end
        at(c + 4);
        pending_check("drop_req");
    endtask

    task automatic test_fixed_pri;
        logic ec, eh;
        @(posedge clk);
        #1;
        fif.cpu_req = 1'b1; fif.cpu_we = 1'b1; fif.cpu_addr = 5'd3; fif.cpu_wdata = 16'h0C0C;
        fif.host_req = 1'b1; fif.host_we = 1'b1; fif.host_addr = 5'd4; fif.host_wdata = 16'h0B0B;
        for (int i = 0; i < 15; i++) begin
            if (i == 12) begin
                @(posedge clk);
                #1;
                fif.cpu_req = 1'b0;
            end
            @(negedge clk);
            ec = (i == 2 || i == 5 || i == 8 || i == 11);
            eh = (i == 14);
            total++;
            if (fif.cpu_ack !== ec || fif.host_ack !== eh) begin
                bad++;
                $display("FAIL fixed_pri_c%0d got cpu_ack=%b host_ack=%b want %b/%b", i, fif.cpu_ack, fif.host_ack, ec, eh);
            end
        end
        @(posedge clk);
        #1;
        fif.host_req = 1'b0;
    endtask

    task automatic test_reset_abort;
        int c, acks, w, s;
        logic ok;
        @(posedge clk);
        #1;
        cif.cpu_req = 1'b1; cif.cpu_we = 1'b1; cif.cpu_addr = 5'd9; cif.cpu_wdata = 16'hDEAD;
        c = cyc;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (cif.busy !== 1'b1 || cif.mem_we !== 1'b1) begin
            bad++;
            $display("FAIL abort_access got busy=%b mem_we=%b want 1/1", cif.busy, cif.mem_we);
        end
        reset = 1'b1;
        cif.cpu_req = 1'b0;
        #1;
        total++;
        if (cif.busy !== 1'b0 || cif.mem_we !== 1'b0 || cif.cpu_ack !== 1'b0) begin
            bad++;
            $display("FAIL abort_reset got busy=%b mem_we=%b ack=%b want 0/0/0", cif.busy, cif.mem_we, cif.cpu_ack);
        end
        at(c + 2);
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cif.cpu_ack || cif.host_ack) acks++;
        end
        total++;
        if (acks != 0) begin
            bad++;
            $display("FAIL abort_noack got=%0d acks want=0", acks);
        end
        txn(1'b0, 1'b0, 5'd31, 16'h0, 16'hBEEF, w, s, ok);
        total++;
        if (!ok || w != 0 || s != 2) begin
            bad++;
            $display("FAIL abort_recover got ack=%b we_cycles=%0d stall_cycles=%0d want 1/0/2", ok, w, s);
        end
        pending_check("reset_abort");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cif.cpu_req = 1'b0; cif.cpu_we = 1'b0; cif.cpu_addr = '0; cif.cpu_wdata = '0;
        cif.host_req = 1'b0; cif.host_we = 1'b0; cif.host_addr = '0; cif.host_wdata = '0;
        fif.cpu_req = 1'b0; fif.cpu_we = 1'b0; fif.cpu_addr = '0; fif.cpu_wdata = '0;
        fif.host_req = 1'b0; fif.host_we = 1'b0; fif.host_addr = '0; fif.host_wdata = '0;
        test_reset();
        test_tie_rr();
        test_cpu_rw();
        test_host_cpu();
        test_back_to_back();
        test_drop_req();
        test_fixed_pri();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
